// File: rtl/filter_sequencer.sv
// Filter-mode sequencer: debounced keys and beat-driven auto-advance request a mode step
// that is applied only on frame_start. Auto-cycling is built when FILTER_SEQUENCER_AUTO_CYCLE_EN is defined.
module filter_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BEATS_PER_MODE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_n,
  input  logic       frame_start,
  input  logic       beat_detected,
  input  logic       calib_done,
  output logic [1:0] mode,
  output logic       thresh_enable,
  output logic       bright_enable,
  output logic       adsr_enable,
  output logic       edge_enable,
  output logic       mode_changed,
  output logic       auto_on
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {CALIB, RUN, PEND} state_e;

  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         db_q, db_d, fall;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       thresh_q, bright_q, adsr_q, edge_q, changed_q;
  logic       apply, adv_req, auto_req, auto_on_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Counter runs only while the synced key disagrees with the debounced level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]   = db_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DLAST) db_d[i] = sync2_q[i];
        else                    dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
      fall[i] = db_q[i] & ~db_d[i];
    end
  end

`ifdef FILTER_SEQUENCER_AUTO_CYCLE_EN
  localparam int BW = $clog2(BEATS_PER_MODE + 1);
  localparam logic [BW-1:0] BMAX = BW'(BEATS_PER_MODE);

  logic [BW-1:0] beat_q, beat_d;
  logic          auto_d;

  // A full counter raises the request for one cycle and clears itself.
  assign auto_req = (beat_q == BMAX);

  always_comb begin
    auto_d = auto_on_q;
    beat_d = beat_q;
    if (state_q != CALIB && fall[1]) auto_d = ~auto_on_q;
    if (!auto_on_q || apply || auto_req) beat_d = '0;
    else if (beat_detected && state_q == RUN) beat_d = beat_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_on_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      auto_on_q <= auto_d;
      beat_q    <= beat_d;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = ^{fall[1], beat_detected};
  assign auto_req    = 1'b0;
  assign auto_on_q   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    apply   = 1'b0;
    adv_req = fall[0] | auto_req;
    unique case (state_q)
      CALIB: if (calib_done) state_d = RUN;
      RUN:   if (adv_req) state_d = PEND;
      PEND: begin
        if (frame_start) begin
          apply   = 1'b1;
          mode_d  = mode_q + 2'd1;
          state_d = RUN;
        end
      end
      default: state_d = CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CALIB;
      mode_q    <= 2'd0;
      thresh_q  <= 1'b0;
      bright_q  <= 1'b0;
      adsr_q    <= 1'b0;
      edge_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      thresh_q  <= (mode_d == 2'd1);
      bright_q  <= (mode_d == 2'd2);
      adsr_q    <= (mode_d == 2'd2);
      edge_q    <= (mode_d == 2'd3);
      changed_q <= apply;
    end
  end

  assign mode          = mode_q;
  assign thresh_enable = thresh_q;
  assign bright_enable = bright_q;
  assign adsr_enable   = adsr_q;
  assign edge_enable   = edge_q;
  assign mode_changed  = changed_q;
  assign auto_on       = auto_on_q;
endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: directed scenarios plus random keys/beats/frames, all checked
// every cycle against a key-history / request-flag model of the sequencer.
module tb_filter_sequencer;
  localparam int N   = 4;
  localparam int BPM = 3;
  localparam int HL  = N + 2;
`ifdef FILTER_SEQUENCER_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_n;
  logic       frame_start, beat_detected, calib_done;
  logic [1:0] mode;
  logic       thresh_enable, bright_enable, adsr_enable, edge_enable, mode_changed, auto_on;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int chg_cnt = 0;

  filter_sequencer #(.DEBOUNCE_CYCLES(N), .BEATS_PER_MODE(BPM)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .frame_start(frame_start),
    .beat_detected(beat_detected), .calib_done(calib_done), .mode(mode),
    .thresh_enable(thresh_enable), .bright_enable(bright_enable),
    .adsr_enable(adsr_enable), .edge_enable(edge_enable),
    .mode_changed(mode_changed), .auto_on(auto_on)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw key history, debounced level, and plain calibrated/pending/mode/auto/beat values.
  bit hist [2][HL];
  bit m_db [2];
  bit m_cal, m_pend, m_auto, m_chg;
  int m_mode, m_beats;
  int en_tab [4] = '{0, 1, 6, 8};  // {edge, adsr, bright, thresh}

  always @(posedge clk) begin
    bit press [2];
    bit flip, apply, run, areq, cal_old, auto_old;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_db[b] = 1'b1;
        for (int k = 0; k < HL; k++) hist[b][k] = 1'b1;
      end
      m_cal = 0; m_pend = 0; m_auto = 0; m_chg = 0; m_mode = 0; m_beats = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = key_n[b];
        // key seen by the debouncer lags the pin by two cycles; needs N in a row
        flip = 1'b1;
        for (int k = 2; k < HL; k++) if (hist[b][k] == m_db[b]) flip = 1'b0;
        press[b] = flip && m_db[b];
        if (flip) m_db[b] = !m_db[b];
      end
      cal_old  = m_cal;
      auto_old = m_auto;
      run      = m_cal && !m_pend;
      apply    = m_cal && m_pend && frame_start;
      areq     = AUTO && (m_beats == BPM);
      m_chg    = apply;
      if (!cal_old) m_cal = calib_done;
      else if (m_pend) begin
        if (frame_start) begin
          m_mode = (m_mode + 1) % 4;
          m_pend = 0;
        end
      end else if (press[0] || areq) m_pend = 1;
      if (AUTO && cal_old && press[1]) m_auto = !m_auto;
      if (!auto_old || apply || areq) m_beats = 0;
      else if (beat_detected && run) m_beats++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mode", mode, m_mode);
      check("enables", {edge_enable, adsr_enable, bright_enable, thresh_enable}, en_tab[m_mode]);
      check("mode_changed", mode_changed, m_chg);
      check("auto_on", auto_on, m_auto);
    end
    if (mode_changed) chg_cnt++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(int b, int hold);
    key_n[b] = 1'b0;
    tick(hold);
    key_n[b] = 1'b1;
    tick(N + 4);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  initial begin
    int khold [2];
    reset = 1'b1; key_n = 2'b11; frame_start = 0; beat_detected = 0; calib_done = 0;
    tick(3);
    chk_en = 1'b1;
    check("reset_mode", mode, 0);
    check("reset_enables", {edge_enable, adsr_enable, bright_enable, thresh_enable}, 0);
    check("reset_changed", mode_changed, 0);
    check("reset_auto", auto_on, 0);
    reset = 1'b0;
    tick(2);

    // key ignored before calibration
    chg_cnt = 0;
    press_key(0, 10);
    frame();
    tick(2);
    check("calib_mode", mode, 0);
    check("calib_pulses", chg_cnt, 0);

    calib_done = 1'b1;
    tick(2);
    chg_cnt = 0;
    press_key(0, 10);
    frame();
    check("first_mode", mode, 1);
    check("first_thresh", thresh_enable, 1);
    check("first_changed", mode_changed, 1);
    tick(3);
    check("first_pulses", chg_cnt, 1);

    // bounce shorter than the debounce window
    press_key(0, 3);
    frame();
    tick(1);
    check("bounce_mode", mode, 1);

    // press coincides with frame_start; extra presses while pending are dropped
    key_n[0] = 1'b0;
    tick(5);
    frame();
    check("coincide_mode", mode, 1);
    tick(4);
    key_n[0] = 1'b1;
    tick(N + 4);
    press_key(0, 6);
    press_key(0, 6);
    frame();
    check("pend_mode", mode, 2);
    check("pend_bright_adsr", {adsr_enable, bright_enable}, 3);
    frame();
    check("pend_single", mode, 2);

    // auto-cycle from beats
    press_key(1, 6);
    check("auto_toggle", auto_on, AUTO ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      beat_detected = 1'b1; tick(1); beat_detected = 1'b0; tick(2);
    end
    tick(2);
    frame();
    check("auto_mode", mode, AUTO ? 3 : 2);
    for (int i = 0; i < 2; i++) begin
      beat_detected = 1'b1; tick(1); beat_detected = 1'b0; tick(2);
    end
    tick(3);
    frame();
    tick(1);
    check("auto_partial", mode, AUTO ? 3 : 2);

    // wrap from mode 3
    if (!AUTO) begin
      press_key(0, 6);
      frame();
    end
    press_key(0, 6);
    frame();
    check("wrap_mode", mode, 0);
    check("wrap_enables", {edge_enable, adsr_enable, bright_enable, thresh_enable}, 0);

    // reset discards a pending request
    press_key(0, 6);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    frame();
    tick(1);
    check("reset_pend_mode", mode, 0);
    check("reset_pend_auto", auto_on, 0);

    khold[0] = 3; khold[1] = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (khold[b] == 0) begin
          key_n[b] = ~key_n[b];
          khold[b] = key_n[b] ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 9));
        end else khold[b]--;
      end
      frame_start   = ($urandom_range(0, 11) == 0);
      beat_detected = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        calib_done = 1'b0;
      end else reset = 1'b0;
      if (!calib_done && $urandom_range(0, 29) == 0) calib_done = 1'b1;
      tick(1);
    end
    reset = 1'b0; frame_start = 0; beat_detected = 0; key_n = 2'b11;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
